npg_profile_scheduler: RTL and testbench

//  Sequencer in front of aska_npg. Holds a table of stimulation profiles and drives the NPG config inputs and enable from them.

---
 rtl/npg_pkg.sv | 39 +++
 rtl/npg_ramp_divider.sv | 58 +++++
 rtl/npg_profile_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_npg_profile_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npg_pkg.sv
// Shared widths, profile record layout and sequencer state encoding for the
// NPG profile scheduler and its ramp divider.
package npg_pkg;
    localparam int AMP_W  = 6;
    localparam int FREQ_W = 12;
    localparam int PH_W   = 3;
    localparam int RAMP_W = 6;
    localparam int ON_W   = 8;
    localparam int OFF_W  = 10;
    localparam int EL_W   = 3;
    localparam int RF_W   = 10;

    localparam logic [3:0] DIV_STEPS = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LOAD,
        ST_CALC,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [AMP_W-1:0]  amplitude;
        logic [FREQ_W-1:0] freq;
        logic [PH_W-1:0]   phase;
        logic [RAMP_W-1:0] ramp;
        logic [ON_W-1:0]   on_time;
        logic [OFF_W-1:0]  off_time;
        logic [EL_W-1:0]   e1;
        logic [EL_W-1:0]   e2;
    } npg_cfg_t;

    // amplitude*16 expressed as the divider's 10-bit dividend
    function automatic logic [RF_W-1:0] amp_to_dividend(input logic [AMP_W-1:0] amp);
        return {amp, 4'b0000};
    endfunction
endpackage

// File: rtl/npg_ramp_divider.sv
// Restoring divider, one quotient bit per clock; done appears a fixed number of
// cycles after start regardless of operands. Divisor 0 yields quotient 0.
module npg_ramp_divider
    import npg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RF_W-1:0]   dividend,
    input  logic [RAMP_W-1:0] divisor,
    output logic [RF_W-1:0]   quotient,
    output logic              done
);
    // dq_reg shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [RF_W-1:0]   dq_reg;
    logic [RAMP_W-1:0] rem_reg;
    logic [RAMP_W-1:0] dvs_reg;
    logic [3:0]        cnt_reg;
    logic              run_reg;
    logic [RAMP_W:0]   trial;
    logic [RAMP_W:0]   diff;
    logic              fits;
    logic [RAMP_W-1:0] rem_next;

    always_comb begin
        trial    = {rem_reg, dq_reg[RF_W-1]};
        diff     = trial - {1'b0, dvs_reg};
        fits     = (trial >= {1'b0, dvs_reg});
        rem_next = fits ? diff[RAMP_W-1:0] : trial[RAMP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dq_reg  <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            dq_reg  <= dividend;
            rem_reg <= '0;
            dvs_reg <= divisor;
            cnt_reg <= '0;
            run_reg <= 1'b1;
        end else if (run_reg) begin
            if (cnt_reg == DIV_STEPS) begin
                run_reg <= 1'b0;
            end else begin
                rem_reg <= rem_next;
                dq_reg  <= {dq_reg[RF_W-2:0], fits};
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign done     = run_reg && (cnt_reg == DIV_STEPS);
    assign quotient = (dvs_reg == '0) ? '0 : dq_reg;
endmodule

// File: rtl/npg_profile_scheduler.sv
// Walks a small table of stimulation profiles, applying each to the NPG for its
// dwell time and only touching NPG configuration while the generator is idle.
module npg_profile_scheduler
    import npg_pkg::*;
#(
    parameter int NUM_PROFILES   = 4,
    parameter int TICKS_PER_UNIT = 20,
    parameter int DWELL_W        = 16,
    localparam int IDX_W         = $clog2(NUM_PROFILES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [AMP_W-1:0]   cfg_amplitude,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [PH_W-1:0]    cfg_phase,
    input  logic [RAMP_W-1:0]  cfg_ramp,
    input  logic [ON_W-1:0]    cfg_on,
    input  logic [OFF_W-1:0]   cfg_off,
    input  logic [EL_W-1:0]    cfg_e1,
    input  logic [EL_W-1:0]    cfg_e2,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic               pulse_active,
    output logic [AMP_W-1:0]   amplitude,
    output logic [FREQ_W-1:0]  freq,
    output logic [PH_W-1:0]    phaseDuration,
    output logic [RAMP_W-1:0]  ramp,
    output logic [ON_W-1:0]    ON_time,
    output logic [OFF_W-1:0]   OFF_time,
    output logic [EL_W-1:0]    electrode1,
    output logic [EL_W-1:0]    electrode2,
    output logic [RF_W-1:0]    ramp_factor,
    output logic               enable,
    output logic               busy,
    output logic [IDX_W-1:0]   active_idx,
    output logic               done,
    output logic               err_empty,
    output logic               cfg_rejected
);
    localparam int PRESC_W = $clog2(TICKS_PER_UNIT + 1);

    sched_state_t       state_reg, state_next;
    npg_cfg_t           cfg_in, cur_cfg, out_cfg_reg;
    npg_cfg_t           tab_cfg   [NUM_PROFILES];
    logic [DWELL_W-1:0] tab_dwell [NUM_PROFILES];
    logic [DWELL_W-1:0] cur_dwell, dwell_reg, unit_reg;
    logic [IDX_W-1:0]   idx_reg, skip_reg, active_idx_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [RF_W-1:0]    rf_reg, div_q;
    logic               loaded_reg, stop_pend_reg;
    logic               done_reg, err_reg, rej_reg;
    logic               wr_ok, last_idx, tick_end, unit_end, div_done;
    logic               idx_clr, idx_inc, skip_inc, load_en, rf_latch;
    logic               done_set, err_set, stop_set;

    assign cfg_in = '{amplitude: cfg_amplitude, freq: cfg_freq, phase: cfg_phase,
                      ramp: cfg_ramp, on_time: cfg_on, off_time: cfg_off,
                      e1: cfg_e1, e2: cfg_e2};
    assign wr_ok  = cfg_we && (state_reg == ST_IDLE);

    for (genvar gi = 0; gi < NUM_PROFILES; gi++) begin : g_tab
        npg_cfg_t           cfg_q;
        logic [DWELL_W-1:0] dwell_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                dwell_q <= '0;
            end else if (wr_ok && (cfg_addr == IDX_W'(gi))) begin
                cfg_q   <= cfg_in;
                dwell_q <= cfg_dwell;
            end
        end
        assign tab_cfg[gi]   = cfg_q;
        assign tab_dwell[gi] = dwell_q;
    end

    assign cur_cfg   = tab_cfg[idx_reg];
    assign cur_dwell = tab_dwell[idx_reg];
    assign last_idx  = (idx_reg == IDX_W'(NUM_PROFILES - 1));
    assign tick_end  = (presc_reg == PRESC_W'(TICKS_PER_UNIT - 1));
    assign unit_end  = tick_end && ((unit_reg + DWELL_W'(1)) == dwell_reg);

    npg_ramp_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (load_en),
        .dividend (amp_to_dividend(cur_cfg.amplitude)),
        .divisor  (cur_cfg.ramp),
        .quotient (div_q),
        .done     (div_done)
    );

    always_comb begin
        state_next = state_reg;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        skip_inc   = 1'b0;
        load_en    = 1'b0;
        rf_latch   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        stop_set   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_SCAN;
                    idx_clr    = 1'b1;
                end
            end
            ST_SCAN: begin
                // the end-of-table check keeps a non-looping session from wrapping
                if (stop) begin
                    state_next = ST_DRAIN;
                    stop_set   = 1'b1;
                end else if (cur_dwell != '0) begin
                    state_next = ST_LOAD;
                end else if (last_idx && !loop && loaded_reg) begin
                    state_next = ST_IDLE;
                    done_set   = 1'b1;
                end else if (skip_reg == IDX_W'(NUM_PROFILES - 1)) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else begin
                    idx_inc  = 1'b1;
                    skip_inc = 1'b1;
                end
            end
            ST_LOAD: begin
                load_en    = 1'b1;
                stop_set   = stop;
                state_next = stop ? ST_DRAIN : ST_CALC;
            end
            ST_CALC: begin
                if (stop) begin
                    state_next = ST_DRAIN;
                    stop_set   = 1'b1;
                end else if (div_done) begin
                    rf_latch   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                stop_set = stop;
                if (stop || unit_end) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                stop_set = stop;
                if (!pulse_active) begin
                    if (stop || stop_pend_reg || (last_idx && !loop)) begin
                        state_next = ST_IDLE;
                        done_set   = 1'b1;
                    end else begin
                        state_next = ST_SCAN;
                        idx_inc    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            skip_reg       <= '0;
            active_idx_reg <= '0;
            loaded_reg     <= 1'b0;
            stop_pend_reg  <= 1'b0;
            presc_reg      <= '0;
            unit_reg       <= '0;
            dwell_reg      <= '0;
            out_cfg_reg    <= '0;
            rf_reg         <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rej_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_set;
            err_reg   <= err_set;
            rej_reg   <= cfg_we && (state_reg != ST_IDLE);
            if (idx_clr) begin
                idx_reg       <= '0;
                skip_reg      <= '0;
                loaded_reg    <= 1'b0;
                stop_pend_reg <= 1'b0;
            end else if (idx_inc) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
            if (skip_inc) skip_reg <= skip_reg + IDX_W'(1);
            if (stop_set) stop_pend_reg <= 1'b1;
            if (load_en) begin
                out_cfg_reg    <= cur_cfg;
                dwell_reg      <= cur_dwell;
                active_idx_reg <= idx_reg;
                presc_reg      <= '0;
                unit_reg       <= '0;
                skip_reg       <= '0;
                loaded_reg     <= 1'b1;
            end
            if (rf_latch) rf_reg <= div_q;
            if (state_reg == ST_RUN) begin
                if (tick_end) begin
                    presc_reg <= '0;
                    unit_reg  <= unit_reg + DWELL_W'(1);
                end else begin
                    presc_reg <= presc_reg + PRESC_W'(1);
                end
            end
        end
    end

    assign amplitude     = out_cfg_reg.amplitude;
    assign freq          = out_cfg_reg.freq;
    assign phaseDuration = out_cfg_reg.phase;
    assign ramp          = out_cfg_reg.ramp;
    assign ON_time       = out_cfg_reg.on_time;
    assign OFF_time      = out_cfg_reg.off_time;
    assign electrode1    = out_cfg_reg.e1;
    assign electrode2    = out_cfg_reg.e2;
    assign ramp_factor   = rf_reg;
    assign enable        = (state_reg == ST_RUN);
    assign busy          = (state_reg != ST_IDLE);
    assign active_idx    = active_idx_reg;
    assign done          = done_reg;
    assign err_empty     = err_reg;
    assign cfg_rejected  = rej_reg;
endmodule

// File: tb/tb_npg_profile_scheduler.sv
// Directed and randomized sessions for npg_profile_scheduler, checked against an
// event-timeline model derived from the profile table.
module tb_npg_profile_scheduler;
    localparam int NP  = 4;
    localparam int TPU = 20;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic [5:0]    cfg_amplitude = '0;
    logic [11:0]   cfg_freq = '0;
    logic [2:0]    cfg_phase = '0;
    logic [5:0]    cfg_ramp = '0;
    logic [7:0]    cfg_on = '0;
    logic [9:0]    cfg_off = '0;
    logic [2:0]    cfg_e1 = '0;
    logic [2:0]    cfg_e2 = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic          pulse_active = 1'b0;
    logic [5:0]    amplitude;
    logic [11:0]   freq;
    logic [2:0]    phaseDuration;
    logic [5:0]    ramp;
    logic [7:0]    ON_time;
    logic [9:0]    OFF_time;
    logic [2:0]    electrode1;
    logic [2:0]    electrode2;
    logic [9:0]    ramp_factor;
    logic          enable;
    logic          busy;
    logic [1:0]    active_idx;
    logic          done;
    logic          err_empty;
    logic          cfg_rejected;

    always #5 clk = ~clk;

    npg_profile_scheduler #(
        .NUM_PROFILES(NP), .TICKS_PER_UNIT(TPU), .DWELL_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_amplitude(cfg_amplitude), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
        .cfg_ramp(cfg_ramp), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_e1(cfg_e1),
        .cfg_e2(cfg_e2), .cfg_dwell(cfg_dwell), .start(start), .stop(stop),
        .loop(loop), .pulse_active(pulse_active), .amplitude(amplitude),
        .freq(freq), .phaseDuration(phaseDuration), .ramp(ramp), .ON_time(ON_time),
        .OFF_time(OFF_time), .electrode1(electrode1), .electrode2(electrode2),
        .ramp_factor(ramp_factor), .enable(enable), .busy(busy),
        .active_idx(active_idx), .done(done), .err_empty(err_empty),
        .cfg_rejected(cfg_rejected)
    );

    int checks = 0;
    int errors = 0;
    int m_amp[NP], m_freq[NP], m_ph[NP], m_ramp[NP], m_on[NP], m_off[NP];
    int m_e1[NP], m_e2[NP], m_dwell[NP];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int i, input int amp, input int fr, input int ph,
                               input int rmp, input int on, input int off,
                               input int e1, input int e2, input int dw);
        cfg_addr = 2'(i); cfg_amplitude = 6'(amp); cfg_freq = 12'(fr); cfg_phase = 3'(ph);
        cfg_ramp = 6'(rmp); cfg_on = 8'(on); cfg_off = 10'(off); cfg_e1 = 3'(e1);
        cfg_e2 = 3'(e2); cfg_dwell = DW'(dw); cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        m_amp[i] = amp; m_freq[i] = fr; m_ph[i] = ph; m_ramp[i] = rmp; m_on[i] = on;
        m_off[i] = off; m_e1[i] = e1; m_e2[i] = e2; m_dwell[i] = dw;
    endtask

    function automatic int model_rf(input int i);
        return (m_ramp[i] == 0) ? 0 : (m_amp[i] * 16) / m_ramp[i];
    endfunction

    task automatic check_cfg(input string tag, input int i);
        chk({tag, " idx"}, int'(active_idx), i);
        chk({tag, " amp"}, int'(amplitude), m_amp[i]);
        chk({tag, " freq"}, int'(freq), m_freq[i]);
        chk({tag, " phase"}, int'(phaseDuration), m_ph[i]);
        chk({tag, " ramp"}, int'(ramp), m_ramp[i]);
        chk({tag, " on"}, int'(ON_time), m_on[i]);
        chk({tag, " off"}, int'(OFF_time), m_off[i]);
        chk({tag, " e1"}, int'(electrode1), m_e1[i]);
        chk({tag, " e2"}, int'(electrode2), m_e2[i]);
        chk({tag, " rf"}, int'(ramp_factor), model_rf(i));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_en(input string tag, input logic lvl, input int budget, output int n);
        n = 0;
        while (enable !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " enable reached"}, int'(enable), int'(lvl));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done seen"}, int'(done), 1);
        tick();
    endtask

    // Session with pulse_active=0, loop=0: each enabled entry costs its scan
    // cycles + 12 to reach RUN, dwell*TPU cycles of enable, then one drain cycle.
    task automatic run_session(input string tag);
        int exp_rise[$], exp_fall[$], exp_ent[$], obs_rise[$], obs_fall[$];
        int t, s, lastv, f, r, exp_end, done_n, done_cnt, err_n, err_cnt, ob;
        logic prev_en;
        t = 1; s = 0; lastv = -1; f = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_dwell[i] != 0) begin
                r = t + (i - s + 1) + 12;
                f = r + m_dwell[i] * TPU;
                exp_rise.push_back(r); exp_fall.push_back(f); exp_ent.push_back(i);
                t = f + 1; s = i + 1; lastv = i;
            end
        end
        exp_end = (lastv < 0) ? 1 + NP : f + 1 + (NP - 1 - lastv);
        done_n = -1; err_n = -1; done_cnt = 0; err_cnt = 0; prev_en = 1'b0;
        start = 1'b1;
        for (int n = 1; n <= exp_end + 3; n++) begin
            tick();
            start = 1'b0;
            if (enable && !prev_en) begin
                obs_rise.push_back(n);
                if (obs_rise.size() <= exp_ent.size())
                    check_cfg($sformatf("%s e%0d", tag, obs_rise.size() - 1),
                              exp_ent[obs_rise.size() - 1]);
            end
            if (!enable && prev_en) obs_fall.push_back(n);
            if (done) begin if (done_n < 0) done_n = n; done_cnt++; end
            if (err_empty) begin if (err_n < 0) err_n = n; err_cnt++; end
            prev_en = enable;
        end
        chk({tag, " rise count"}, obs_rise.size(), exp_rise.size());
        for (int k = 0; k < exp_rise.size(); k++) begin
            ob = (k < obs_rise.size()) ? obs_rise[k] : -1;
            chk($sformatf("%s rise%0d edge", tag, k), ob, exp_rise[k]);
            ob = (k < obs_fall.size()) ? obs_fall[k] : -1;
            chk($sformatf("%s fall%0d edge", tag, k), ob, exp_fall[k]);
        end
        if (lastv < 0) begin
            chk({tag, " err edge"}, err_n, exp_end);
            chk({tag, " err cycles"}, err_cnt, 1);
            chk({tag, " done cycles"}, done_cnt, 0);
        end else begin
            chk({tag, " done edge"}, done_n, exp_end);
            chk({tag, " done cycles"}, done_cnt, 1);
            chk({tag, " err cycles"}, err_cnt, 0);
        end
        chk({tag, " busy end"}, int'(busy), 0);
        $display("session %s: entries=%0d end_edge=%0d", tag, exp_rise.size(), exp_end);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NP; i++) begin
            m_amp[i] = 0; m_freq[i] = 0; m_ph[i] = 0; m_ramp[i] = 0; m_on[i] = 0;
            m_off[i] = 0; m_e1[i] = 0; m_e2[i] = 0; m_dwell[i] = 0;
        end
        tick(); tick();
        reset = 1'b0;
        chk("reset enable", int'(enable), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset amp", int'(amplitude), 0);
        chk("reset rf", int'(ramp_factor), 0);
        chk("reset idx", int'(active_idx), 0);
        chk("reset pulses", int'({done, err_empty, cfg_rejected}), 0);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start+stop idle", int'(busy), 0);

        // Single entry, amp 50 / ramp 50 -> factor 16, 40 enabled cycles
        write_entry(0, 50, 100, 3, 50, 10, 20, 1, 2, 2);
        for (int i = 1; i < NP; i++) write_entry(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_session("T1");

        // Entry 1 skipped between 0 and 2; entry 2 has no ramp
        write_entry(0, 12, 7, 1, 4, 3, 5, 2, 3, 1);
        write_entry(2, 40, 999, 6, 0, 77, 500, 4, 5, 1);
        run_session("T2");

        for (int i = 0; i < NP; i++) write_entry(i, 9, 9, 1, 3, 1, 1, 1, 1, 0);
        run_session("T5 empty");

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NP; i++)
                write_entry(i, $urandom_range(0, 50), $urandom_range(0, 4095),
                            $urandom_range(0, 7), $urandom_range(0, 63),
                            $urandom_range(0, 255), $urandom_range(0, 1023),
                            $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 2));
            run_session($sformatf("rand%0d", r));
        end

        // Dwell ends with a pulse in flight: config must hold until it finishes
        write_entry(0, 30, 11, 2, 10, 4, 8, 1, 6, 1);
        write_entry(1, 20, 22, 5, 5, 9, 3, 7, 0, 1);
        write_entry(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        write_entry(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_start();
        wait_en("T3 rise0", 1'b1, 30, n);
        chk("T3 first enable latency", n, 13);
        pulse_active = 1'b1;
        wait_en("T3 fall0", 1'b0, 40, n);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("T3 hold%0d enable", c), int'(enable), 0);
            chk($sformatf("T3 hold%0d amp", c), int'(amplitude), 30);
            chk($sformatf("T3 hold%0d idx", c), int'(active_idx), 0);
        end
        pulse_active = 1'b0;
        wait_en("T3 rise1", 1'b1, 30, n);
        chk("T3 reload latency", n, 14);
        check_cfg("T3 e1", 1);
        wait_done("T3", 60);

        // stop mid-RUN with a pulse in flight; loop must not restart
        write_entry(0, 25, 1, 1, 5, 1, 1, 1, 1, 5);
        write_entry(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        loop = 1'b1;
        pulse_start();
        wait_en("T4 rise", 1'b1, 30, n);
        for (int c = 0; c < 10; c++) tick();
        pulse_active = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("T4 enable after stop", int'(enable), 0);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("T4 wait%0d busy/done", c), int'({busy, done}), 2);
        end
        pulse_active = 1'b0;
        tick();
        chk("T4 done", int'(done), 1);
        chk("T4 busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("T4 after%0d en/busy/done", c), int'({enable, busy, done}), 0);
        end
        loop = 1'b0;

        // Write while busy is dropped
        write_entry(0, 10, 1, 1, 3, 1, 1, 1, 1, 1);
        pulse_start();
        tick(); tick();
        cfg_addr = 2'd3; cfg_dwell = DW'(7); cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("T6 rejected pulse", int'(cfg_rejected), 1);
        tick();
        chk("T6 rejected clears", int'(cfg_rejected), 0);
        wait_done("T6", 100);
        run_session("T6 table intact");

        // Reset during RUN clears everything at that edge
        pulse_start();
        wait_en("T6 reset rise", 1'b1, 30, n);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("T6 reset enable", int'(enable), 0);
        chk("T6 reset busy", int'(busy), 0);
        chk("T6 reset amp", int'(amplitude), 0);
        chk("T6 reset rf", int'(ramp_factor), 0);
        chk("T6 reset freq", int'(freq), 0);
        for (int i = 0; i < NP; i++) m_dwell[i] = 0;
        run_session("post-reset empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
